frame_serializer_hs: RTL and testbench

- Parametrised successor to the fixed 32-bit frame serializer on the clk1280 domain.
- Adds a valid/ready frame input with a one-entry holding buffer and selectable bit order.
- Inserts an idle pattern on underrun, plus an enable with clean frame-boundary stop and start.
- Sits between the frame builder and the serial output pin logic.

---
 rtl/serdes_pkg.sv | 25 ++
 rtl/frame_serializer_hs_if.sv | 23 ++
 rtl/serdes_frame_hold.sv | 47 ++++
 rtl/frame_serializer_hs.sv | 139 +++++++++++++
 tb/tb_frame_serializer_hs.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/serdes_pkg.sv
// Shared types and helpers for the frame serializer family.
// The bit selector is written to be reused by a matching deserializer.
package serdes_pkg;

  localparam int MAX_FRAME_W = 64;

  // Repeating comma-like pattern; instances slice it down to their frame width.
  localparam logic [MAX_FRAME_W-1:0] IDLE_PATTERN_DEFAULT = 64'hBCBC_BCBC_BCBC_BCBC;

  typedef enum logic [0:0] {
    ST_OFF = 1'b0,
    ST_RUN = 1'b1
  } serdes_state_e;

  // Returns the bit that goes on the wire at position idx of a frame of the given width.
  function automatic logic bit_sel(input logic [MAX_FRAME_W-1:0] frame,
                                   input logic [5:0]             idx,
                                   input bit                     msb_first,
                                   input logic [6:0]             width);
    logic [6:0] pos;
    pos = msb_first ? (width - 7'd1 - {1'b0, idx}) : {1'b0, idx};
    return frame[pos[5:0]];
  endfunction

endpackage

// File: rtl/frame_serializer_hs_if.sv
// Frame input handshake between the frame builder and the serializer.
// A transfer happens on a rising edge where frame_valid and frame_ready are both high.
interface frame_serializer_hs_if #(
  parameter int FRAME_W = 32
) ();

  logic [FRAME_W-1:0] frame_data;
  logic               frame_valid;
  logic               frame_ready;

  modport master (
    output frame_data,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_valid,
    output frame_ready
  );

endinterface

// File: rtl/serdes_frame_hold.sv
// One-entry valid/ready holding register. take_i empties it; a frame arriving on
// the same edge as a take replaces the departing one, so nothing is lost or duplicated.
module serdes_frame_hold #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         take_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         xfer;

  assign in_ready_o = !rst_i && (!valid_q || take_i);
  assign xfer       = in_valid_i && in_ready_o;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (take_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/frame_serializer_hs.sv
// Frame-to-bit serializer on the bit clock with a one-entry input buffer, idle-frame
// insertion on underrun and tx_en honoured only at frame boundaries.
module frame_serializer_hs
  import serdes_pkg::*;
#(
  parameter int                 FRAME_W      = 32,
  parameter bit                 MSB_FIRST    = 1'b1,
  parameter logic [FRAME_W-1:0] IDLE_PATTERN = IDLE_PATTERN_DEFAULT[FRAME_W-1:0],
  parameter int                 UCNT_W       = 16
) (
  input  logic                  clk1280,
  input  logic                  rst,
  frame_serializer_hs_if.slave  frm,
  input  logic                  tx_en,
  output logic                  data_tx,
  output logic                  frame_start,
  output logic                  idle_active,
  output logic [UCNT_W-1:0]     underrun_cnt,
  output serdes_state_e         dbg_state_o
);

  localparam int               CNT_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_W - 1);

  serdes_state_e      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               data_tx_q, data_tx_d;
  logic               fs_q, fs_d;
  logic               idle_q, idle_d;
  logic [UCNT_W-1:0]  ucnt_q, ucnt_d;

  logic               load;
  logic               take;
  logic               hold_valid;
  logic [FRAME_W-1:0] hold_data;
  logic [FRAME_W-1:0] src;

  serdes_frame_hold #(
    .W (FRAME_W)
  ) u_hold (
    .clk_i      (clk1280),
    .rst_i      (rst),
    .in_data_i  (frm.frame_data),
    .in_valid_i (frm.frame_valid),
    .in_ready_o (frm.frame_ready),
    .take_i     (take),
    .valid_o    (hold_valid),
    .data_o     (hold_data)
  );

  assign src = hold_valid ? hold_data : IDLE_PATTERN;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    data_tx_d = data_tx_q;
    fs_d      = 1'b0;
    idle_d    = idle_q;
    ucnt_d    = ucnt_q;
    load      = 1'b0;

    case (state_q)
      ST_OFF: begin
        data_tx_d = 1'b0;
        idle_d    = 1'b0;
        cnt_d     = '0;
        if (tx_en) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == LAST) begin
          if (tx_en) begin
            load = 1'b1;
          end else begin
            state_d   = ST_OFF;
            data_tx_d = 1'b0;
            idle_d    = 1'b0;
            cnt_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (MSB_FIRST) begin
            data_tx_d = shift_q[FRAME_W-1];
            shift_d   = shift_q << 1;
          end else begin
            data_tx_d = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      default: state_d = ST_OFF;
    endcase

    // The first bit goes straight to the output register; the rest wait in the shifter.
    if (load) begin
      cnt_d     = '0;
      data_tx_d = bit_sel(64'(src), 6'd0, MSB_FIRST, 7'(FRAME_W));
      fs_d      = 1'b1;
      idle_d    = !hold_valid;
      shift_d   = MSB_FIRST ? (src << 1) : (src >> 1);
      if (!hold_valid && (ucnt_q != {UCNT_W{1'b1}})) begin
        ucnt_d = ucnt_q + 1'b1;
      end
    end

    take = load && hold_valid;
  end

  always_ff @(posedge clk1280) begin
    if (rst) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      shift_q   <= '0;
      data_tx_q <= 1'b0;
      fs_q      <= 1'b0;
      idle_q    <= 1'b0;
      ucnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      data_tx_q <= data_tx_d;
      fs_q      <= fs_d;
      idle_q    <= idle_d;
      ucnt_q    <= ucnt_d;
    end
  end

  assign data_tx      = data_tx_q;
  assign frame_start  = fs_q;
  assign idle_active  = idle_q;
  assign underrun_cnt = ucnt_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_frame_serializer_hs.sv
// Directed bench for frame_serializer_hs: a 32-bit MSB-first instance and a
// 20-bit LSB-first instance with a 2-bit underrun counter.
module tb_frame_serializer_hs;
  import serdes_pkg::*;

  logic clk1280;
  initial clk1280 = 1'b0;
  always #5 clk1280 = ~clk1280;

  // Instance A: FRAME_W=32, MSB_FIRST=1, UCNT_W=16
  logic          a_rst, a_tx_en, a_data_tx, a_fs, a_idle;
  logic [15:0]   a_ucnt;
  serdes_state_e a_state;
  frame_serializer_hs_if #(.FRAME_W(32)) a_if ();

  frame_serializer_hs #(
    .FRAME_W(32), .MSB_FIRST(1'b1), .IDLE_PATTERN(32'hBCBC_BCBC), .UCNT_W(16)
  ) u_a (
    .clk1280(clk1280), .rst(a_rst), .frm(a_if), .tx_en(a_tx_en),
    .data_tx(a_data_tx), .frame_start(a_fs), .idle_active(a_idle),
    .underrun_cnt(a_ucnt), .dbg_state_o(a_state)
  );

  // Instance B: FRAME_W=20, MSB_FIRST=0, UCNT_W=2
  logic          b_rst, b_tx_en, b_data_tx, b_fs, b_idle;
  logic [1:0]    b_ucnt;
  serdes_state_e b_state;
  frame_serializer_hs_if #(.FRAME_W(20)) b_if ();

  frame_serializer_hs #(
    .FRAME_W(20), .MSB_FIRST(1'b0), .IDLE_PATTERN(20'hCBCBC), .UCNT_W(2)
  ) u_b (
    .clk1280(clk1280), .rst(b_rst), .frm(b_if), .tx_en(b_tx_en),
    .data_tx(b_data_tx), .frame_start(b_fs), .idle_active(b_idle),
    .underrun_cnt(b_ucnt), .dbg_state_o(b_state)
  );

  // Scoreboard entry: {data_tx, frame_start, idle_active, underrun_cnt[15:0]}
  logic [18:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int model_ucnt = 0;
  int ucnt_max = 65535;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [63:0] f, input int w, input bit msb,
                            input bit idle, input int nbits);
    logic [63:0] tmp;
    if (idle && model_ucnt < ucnt_max) model_ucnt++;
    for (int i = 0; i < nbits; i++) begin
      tmp = msb ? (f >> (w - 1 - i)) : (f >> i);
      exp_q.push_back({tmp[0], (i == 0), idle, 16'(model_ucnt)});
    end
  endtask

  task automatic push_off(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({3'b000, 16'(model_ucnt)});
  endtask

  task automatic check_pop(input string tag, input logic d, input logic fs,
                           input logic idle, input logic [15:0] ucnt);
    logic [18:0] e;
    tests++;
    assert (exp_q.size() != 0) else begin
      fails++;
      $error("FAIL %s_underflow observed=output expected=none", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_data_tx"}, 32'(d), 32'(e[18]));
      chk({tag, "_frame_start"}, 32'(fs), 32'(e[17]));
      chk({tag, "_idle_active"}, 32'(idle), 32'(e[16]));
      chk({tag, "_underrun_cnt"}, 32'(ucnt), 32'(e[15:0]));
    end
  endtask

  task automatic tick_a();
    @(posedge clk1280); #1;
    check_pop("a", a_data_tx, a_fs, a_idle, a_ucnt);
  endtask

  task automatic tick_b();
    @(posedge clk1280); #1;
    check_pop("b", b_data_tx, b_fs, b_idle, {14'b0, b_ucnt});
  endtask

  task automatic reset_a();
    a_rst = 1'b1; a_tx_en = 1'b0; a_if.frame_valid = 1'b0;
    model_ucnt = 0;
    push_off(2);
    repeat (2) begin
      tick_a();
      chk("a_rst_ready", 32'(a_if.frame_ready), 32'd0);
      chk("a_rst_state", 32'(a_state), 32'(ST_OFF));
    end
    a_rst = 1'b0;
  endtask

  task automatic reset_b();
    b_rst = 1'b1; b_tx_en = 1'b0; b_if.frame_valid = 1'b0;
    model_ucnt = 0;
    push_off(2);
    repeat (2) begin
      tick_b();
      chk("b_rst_ready", 32'(b_if.frame_ready), 32'd0);
      chk("b_rst_state", 32'(b_state), 32'(ST_OFF));
    end
    b_rst = 1'b0;
  endtask

  initial begin
    a_rst = 1'b1; a_tx_en = 1'b0; a_if.frame_valid = 1'b0; a_if.frame_data = '0;
    b_rst = 1'b1; b_tx_en = 1'b0; b_if.frame_valid = 1'b0; b_if.frame_data = '0;
    ucnt_max = 65535;

    // Idle-only run: three idle frames, counter 1, 2, 3
    reset_a();
    a_tx_en = 1'b1;
    repeat (3) push_frame(64'hBCBC_BCBC, 32, 1'b1, 1'b1, 32);
    repeat (96) tick_a();

    // Back-to-back frames behind one idle frame (no bypass)
    reset_a();
    a_tx_en = 1'b1; a_if.frame_valid = 1'b1; a_if.frame_data = 32'hDEAD_BEEF;
    #1;
    chk("a_ready_empty", 32'(a_if.frame_ready), 32'd1);
    push_frame(64'hBCBC_BCBC, 32, 1'b1, 1'b1, 32);
    push_frame(64'hDEAD_BEEF, 32, 1'b1, 1'b0, 32);
    push_frame(64'h0123_4567, 32, 1'b1, 1'b0, 32);
    tick_a();
    a_if.frame_data = 32'h0123_4567;
    chk("a_ready_full", 32'(a_if.frame_ready), 32'd0);
    repeat (30) begin
      tick_a();
      chk("a_ready_busy", 32'(a_if.frame_ready), 32'd0);
    end
    tick_a();
    chk("a_ready_boundary", 32'(a_if.frame_ready), 32'd1);
    tick_a();
    a_if.frame_valid = 1'b0;
    repeat (63) tick_a();

    // tx_en dropped at bit 5 of a frame: frame completes, next offer is held while OFF
    a_if.frame_valid = 1'b1; a_if.frame_data = 32'hFFFF_0000;
    push_frame(64'hBCBC_BCBC, 32, 1'b1, 1'b1, 32);
    push_frame(64'hFFFF_0000, 32, 1'b1, 1'b0, 32);
    tick_a();
    a_if.frame_valid = 1'b0;
    repeat (37) tick_a();
    a_tx_en = 1'b0; a_if.frame_valid = 1'b1; a_if.frame_data = 32'hA5A5_A5A5;
    #1;
    chk("a_ready_midframe", 32'(a_if.frame_ready), 32'd1);
    tick_a();
    a_if.frame_valid = 1'b0;
    repeat (25) tick_a();
    push_off(5);
    repeat (5) begin
      tick_a();
      chk("a_off_state", 32'(a_state), 32'(ST_OFF));
      chk("a_off_ready", 32'(a_if.frame_ready), 32'd0);
    end
    a_tx_en = 1'b1;
    push_frame(64'hA5A5_A5A5, 32, 1'b1, 1'b0, 32);
    repeat (32) tick_a();
    a_tx_en = 1'b0;
    push_off(2);
    repeat (2) tick_a();

    // Reset at bit 10 of a user frame with another frame held
    a_tx_en = 1'b1; a_if.frame_valid = 1'b1; a_if.frame_data = 32'h1234_5678;
    push_frame(64'hBCBC_BCBC, 32, 1'b1, 1'b1, 32);
    tick_a();
    a_if.frame_data = 32'h8765_4321;
    repeat (31) tick_a();
    push_frame(64'h1234_5678, 32, 1'b1, 1'b0, 11);
    tick_a();
    a_if.frame_valid = 1'b0;
    repeat (10) tick_a();
    chk("a_ready_held", 32'(a_if.frame_ready), 32'd0);
    reset_a();
    a_tx_en = 1'b1;
    repeat (2) push_frame(64'hBCBC_BCBC, 32, 1'b1, 1'b1, 32);
    repeat (64) tick_a();
    a_tx_en = 1'b0;
    push_off(2);
    repeat (2) tick_a();

    // Instance B: 2-bit counter saturation, then an LSB-first 20-bit frame
    ucnt_max = 3;
    reset_b();
    b_tx_en = 1'b1;
    repeat (5) push_frame(64'hC_BCBC, 20, 1'b0, 1'b1, 20);
    repeat (80) tick_b();
    b_if.frame_valid = 1'b1; b_if.frame_data = 20'h00001;
    tick_b();
    b_if.frame_valid = 1'b0;
    repeat (19) tick_b();
    push_frame(64'h0_0001, 20, 1'b0, 1'b0, 20);
    repeat (20) tick_b();
    b_tx_en = 1'b0;
    push_off(3);
    repeat (3) tick_b();
    chk("b_off_state", 32'(b_state), 32'(ST_OFF));

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
